// File: rtl/mcp300x_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mcp300x_pkg                                                      |
// | Purpose : Shared types and frame constants for the MCP300x/320x scanner.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mcp300x_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b1;

  // SCK periods (1-based) carrying the ADC sample slot and the null bit.
  // Result bits start on the period after the null bit.
  localparam int SAMPLE_BIT_POS = 6;
  localparam int NULL_BIT_POS   = SAMPLE_BIT_POS + 1;
  localparam int FIRST_DATA_POS = NULL_BIT_POS + 1;

  // 5 command bits + sample slot + null bit + result bits.
  function automatic int frame_bits(input int data_w);
    return data_w + 7;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcp300x_scanner_sck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_sck_gen                                                      |
// | Purpose : Mode-0 SPI clock generator. While en is high, SCK toggles every  |
// |           CLK_DIV clk cycles starting low; rise_tick/fall_tick flag the    |
// |           clk edge that will drive SCK 0->1 / 1->0. Disabled => SCK low.   |
// | Ports   : clk, rst_n (async active-low), en -> spi_sck, rise_tick,         |
// |           fall_tick                                                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic spi_sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;

  always_comb begin
    cnt_d     = cnt_q;
    sck_d     = sck_q;
    rise_tick = 1'b0;
    fall_tick = 1'b0;
    if (!en) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      sck_d     = ~sck_q;
      rise_tick = ~sck_q;
      fall_tick = sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign spi_sck = sck_q;

endmodule
`default_nettype wire

// File: rtl/mcp300x_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mcp300x_scanner                                                  |
// | Purpose : SPI master scanning a masked set of MCP300x/320x ADC channels,   |
// |           one-shot or continuous, single-ended or differential. Each       |
// |           conversion is strobed out and stored in a per-channel bank.      |
// | Ports   : clk, rst_n (async active-low)                                    |
// |           start, cont_en, ch_mask[NUM_CH], diff_mode  - scan control       |
// |           busy, smp_valid, smp_ch[3], smp_data[DATA_W], scan_done          |
// |           results[NUM_CH*DATA_W] - channel k at [k*DATA_W +: DATA_W]       |
// |           spi_sck, spi_cs_n, spi_mosi, spi_miso - ADC interface (mode 0)   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mcp300x_scanner
  import mcp300x_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 10,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cont_en,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     diff_mode,
  output logic                     busy,
  output logic                     smp_valid,
  output logic [2:0]               smp_ch,
  output logic [DATA_W-1:0]        smp_data,
  output logic                     scan_done,
  output logic [NUM_CH*DATA_W-1:0] results,
  output logic                     spi_sck,
  output logic                     spi_cs_n,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  localparam int             FRAME      = frame_bits(DATA_W);
  localparam int             BCW        = $clog2(FRAME + 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME);
  localparam logic [BCW-1:0] FIRST_DATA = BCW'(FIRST_DATA_POS);
  localparam int             CNT_MAX    = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int             CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'(CS_GAP - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BCW-1:0]           bit_q, bit_d;
  logic [2:0]               ch_q, ch_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic                     diff_q, diff_d;
  logic                     busy_q, busy_d;
  logic                     cs_n_q, cs_n_d;
  logic                     mosi_q, mosi_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic                     smp_valid_q, smp_valid_d;
  logic                     scan_done_q, scan_done_d;
  logic [2:0]               smp_ch_q, smp_ch_d;
  logic [DATA_W-1:0]        smp_data_q, smp_data_d;
  logic [NUM_CH*DATA_W-1:0] results_q, results_d;

  logic sck_en, rise_tick, fall_tick;

  assign sck_en = (state_q == S_SHIFT);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (sck_en),
    .spi_sck   (spi_sck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // first_ch: lowest enabled channel of the live mask (used at scan start).
  // next_ch : next enabled channel above the current one in the latched mask.
  logic [2:0] first_ch, next_ch;
  logic       has_next;

  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_mask[k]) first_ch = 3'(k);
      if (mask_q[k] && (3'(k) > ch_q)) begin
        next_ch  = 3'(k);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    diff_d      = diff_q;
    busy_d      = busy_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    shift_d     = shift_q;
    smp_valid_d = 1'b0;
    scan_done_d = 1'b0;
    smp_ch_d    = smp_ch_q;
    smp_data_d  = smp_data_q;
    results_d   = results_q;

    case (state_q)
      S_IDLE: begin
        if (start && (|ch_mask)) begin
          mask_d  = ch_mask;
          diff_d  = diff_mode;
          ch_d    = first_ch;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = START_BIT;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = BCW'(1);
          shift_d = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SHIFT: begin
        if (rise_tick && (bit_q >= FIRST_DATA)) begin
          shift_d = {shift_q[DATA_W-2:0], spi_miso};
        end
        if (fall_tick) begin
          if (bit_q == LAST_BIT) begin
            cnt_d   = '0;
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end else begin
            bit_d = bit_q + BCW'(1);
            // Present the bit for the period that starts on this falling edge.
            case (bit_q)
              BCW'(1): mosi_d = ~diff_q;
              BCW'(2): mosi_d = ch_q[2];
              BCW'(3): mosi_d = ch_q[1];
              BCW'(4): mosi_d = ch_q[0];
              default: mosi_d = 1'b0;
            endcase
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d       = '0;
          cs_n_d      = 1'b1;
          smp_valid_d = 1'b1;
          scan_done_d = ~has_next;
          smp_ch_d    = ch_q;
          smp_data_d  = shift_q;
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == 3'(k)) results_d[k*DATA_W +: DATA_W] = shift_q;
          end
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (has_next) begin
            ch_d    = next_ch;
            cs_n_d  = 1'b0;
            mosi_d  = START_BIT;
            state_d = S_SETUP;
          end else if (cont_en && (|ch_mask)) begin
            mask_d  = ch_mask;
            diff_d  = diff_mode;
            ch_d    = first_ch;
            cs_n_d  = 1'b0;
            mosi_d  = START_BIT;
            state_d = S_SETUP;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      ch_q        <= '0;
      mask_q      <= '0;
      diff_q      <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      shift_q     <= '0;
      smp_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      smp_ch_q    <= '0;
      smp_data_q  <= '0;
      results_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      diff_q      <= diff_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      shift_q     <= shift_d;
      smp_valid_q <= smp_valid_d;
      scan_done_q <= scan_done_d;
      smp_ch_q    <= smp_ch_d;
      smp_data_q  <= smp_data_d;
      results_q   <= results_d;
    end
  end

  assign busy      = busy_q;
  assign smp_valid = smp_valid_q;
  assign scan_done = scan_done_q;
  assign smp_ch    = smp_ch_q;
  assign smp_data  = smp_data_q;
  assign results   = results_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp300x_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mcp300x_scanner                                               |
// | Purpose : Directed self-checking bench for mcp300x_scanner. Instance A is  |
// |           10-bit / CLK_DIV=2, instance B is 12-bit / CLK_DIV=1. Each ADC   |
// |           model decodes the command and returns a known word on MISO.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mcp300x_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: 10-bit, CLK_DIV=2, CS_GAP=8 ----------------
  logic        start_a, cont_a, diff_a;
  logic [7:0]  mask_a;
  logic        busy_a, smp_valid_a, scan_done_a, sck_a, cs_n_a, mosi_a, miso_a;
  logic [2:0]  smp_ch_a;
  logic [9:0]  smp_data_a;
  logic [79:0] results_a;

  mcp300x_scanner #(.NUM_CH(8), .DATA_W(10), .CLK_DIV(2), .CS_GAP(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont_en(cont_a),
    .ch_mask(mask_a), .diff_mode(diff_a), .busy(busy_a),
    .smp_valid(smp_valid_a), .smp_ch(smp_ch_a), .smp_data(smp_data_a),
    .scan_done(scan_done_a), .results(results_a), .spi_sck(sck_a),
    .spi_cs_n(cs_n_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  // ---------------- instance B: 12-bit, CLK_DIV=1, CS_GAP=3 ----------------
  logic        start_b, cont_b, diff_b;
  logic [7:0]  mask_b;
  logic        busy_b, smp_valid_b, scan_done_b, sck_b, cs_n_b, mosi_b, miso_b;
  logic [2:0]  smp_ch_b;
  logic [11:0] smp_data_b;
  logic [95:0] results_b;

  mcp300x_scanner #(.NUM_CH(8), .DATA_W(12), .CLK_DIV(1), .CS_GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont_en(cont_b),
    .ch_mask(mask_b), .diff_mode(diff_b), .busy(busy_b),
    .smp_valid(smp_valid_b), .smp_ch(smp_ch_b), .smp_data(smp_data_b),
    .scan_done(scan_done_b), .results(results_b), .spi_sck(sck_b),
    .spi_cs_n(cs_n_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  // ADC model: result bit for SCK period p (1-based), MSB first from period 8.
  function automatic logic miso_bit(input int period, input int val, input int dw);
    if (period >= 8 && period < 8 + dw) return val[dw - 1 - (period - 8)];
    return 1'b0;
  endfunction

  // ---------------- bus monitors (edges observed at negedge clk) ----------
  int         rise_a = 0, rise_b = 0;
  logic [4:0] cmd_a = '0;
  logic       prev_sck_a = 1'b0, prev_cs_a = 1'b1;
  logic       prev_sck_b = 1'b0, prev_cs_b = 1'b1;
  int         n_smp_a = 0, n_done_a = 0, busy_low_a = 0;
  int         hi_run_a = 0, min_gap_a = 1000;
  logic       use_fixed_a = 1'b1;

  assign miso_a = miso_bit(rise_a + 1, use_fixed_a ? 32'h2A5 : (32'h100 + 32'(cmd_a[2:0])), 10);
  assign miso_b = miso_bit(rise_b + 1, 32'hABC, 12);

  always @(negedge clk) begin
    if (prev_cs_a && !cs_n_a) begin
      rise_a = 0;
      cmd_a  = '0;
    end
    if (!prev_sck_a && sck_a) begin
      if (rise_a < 5) cmd_a = {cmd_a[3:0], mosi_a};
      rise_a++;
    end
    if (smp_valid_a) n_smp_a++;
    if (scan_done_a) n_done_a++;
    if (!busy_a) busy_low_a++;
    if (busy_a && cs_n_a) hi_run_a++;
    else if (hi_run_a > 0) begin
      if (hi_run_a < min_gap_a) min_gap_a = hi_run_a;
      hi_run_a = 0;
    end
    prev_sck_a = sck_a;
    prev_cs_a  = cs_n_a;
  end

  always @(negedge clk) begin
    if (prev_cs_b && !cs_n_b) rise_b = 0;
    if (!prev_sck_b && sck_b) rise_b++;
    prev_sck_b = sck_b;
    prev_cs_b  = cs_n_b;
  end

  // ---------------- checking and helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_a_pulse(input logic [7:0] mask, input logic diff);
    @(negedge clk);
    mask_a  = mask;
    diff_a  = diff;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_smp_a(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!smp_valid_a && cyc < budget);
    check_eq("smp_valid_a arrives", 32'(smp_valid_a), 32'd1);
  endtask

  task automatic expect_a(input string tag, input int ch, input int data, input int done);
    int cyc;
    wait_smp_a(200, cyc);
    check_eq({tag, " ch"},    32'(smp_ch_a),    ch);
    check_eq({tag, " data"},  32'(smp_data_a),  data);
    check_eq({tag, " done"},  32'(scan_done_a), done);
    check_eq({tag, " rises"}, rise_a,           17);
  endtask

  task automatic wait_idle_a(input string tag);
    int cyc;
    cyc = 0;
    while (busy_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " idle"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int cyc, snap0, snap1;
    rst_n   = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; diff_a = 1'b0; mask_a = '0;
    start_b = 1'b0; cont_b = 1'b0; diff_b = 1'b0; mask_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst cs_n",      32'(cs_n_a),      32'd1);
    check_eq("rst sck",       32'(sck_a),       32'd0);
    check_eq("rst mosi",      32'(mosi_a),      32'd0);
    check_eq("rst busy",      32'(busy_a),      32'd0);
    check_eq("rst smp_valid", 32'(smp_valid_a), 32'd0);
    check_eq("rst scan_done", 32'(scan_done_a), 32'd0);
    check_eq("rst smp_ch",    32'(smp_ch_a),    32'd0);
    check_eq("rst smp_data",  32'(smp_data_a),  32'd0);
    check_eq("rst results",   32'(|results_a),  32'd0);

    // Start with empty mask is ignored
    snap0 = n_smp_a;
    start_a_pulse(8'h00, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("mask0 busy", 32'(busy_a), 32'd0);
    check_eq("mask0 cs_n", 32'(cs_n_a), 32'd1);
    check_eq("mask0 smp",  n_smp_a - snap0, 0);

    // Single channel, single-ended, fixed 0x2A5
    use_fixed_a = 1'b1;
    start_a_pulse(8'h01, 1'b0);
    check_eq("t1 busy", 32'(busy_a), 32'd1);
    wait_smp_a(200, cyc);
    check_eq("t1 latency", cyc + 1, 73);
    check_eq("t1 ch",      32'(smp_ch_a),      32'd0);
    check_eq("t1 data",    32'(smp_data_a),    32'h2A5);
    check_eq("t1 done",    32'(scan_done_a),   32'd1);
    check_eq("t1 cs_n",    32'(cs_n_a),        32'd1);
    check_eq("t1 rises",   rise_a,             17);
    check_eq("t1 cmd",     32'(cmd_a),         32'b11000);
    check_eq("t1 res0",    32'(results_a[9:0]), 32'h2A5);
    wait_idle_a("t1");

    // Sparse mask 0xA4: ch2, ch5, ch7
    use_fixed_a = 1'b0;
    snap0 = n_done_a;
    start_a_pulse(8'hA4, 1'b0);
    expect_a("t2 s0", 2, 32'h102, 0);
    expect_a("t2 s1", 5, 32'h105, 0);
    expect_a("t2 s2", 7, 32'h107, 1);
    wait_idle_a("t2");
    check_eq("t2 done count", n_done_a - snap0, 1);
    check_eq("t2 cs gap ok",  32'(min_gap_a >= 8), 32'd1);
    check_eq("t2 res2", 32'(results_a[29:20]), 32'h102);
    check_eq("t2 res5", 32'(results_a[59:50]), 32'h105);
    check_eq("t2 res7", 32'(results_a[79:70]), 32'h107);
    check_eq("t2 res0 kept", 32'(results_a[9:0]),   32'h2A5);
    check_eq("t2 res1 kept", 32'(results_a[19:10]), 32'h000);

    // Differential ch3; mask/diff changes mid-scan have no effect
    snap0 = n_smp_a;
    start_a_pulse(8'h08, 1'b1);
    mask_a = 8'hFF;
    diff_a = 1'b0;
    expect_a("t3", 3, 32'h103, 1);
    check_eq("t3 cmd", 32'(cmd_a), 32'b10011);
    wait_idle_a("t3");
    check_eq("t3 smp count", n_smp_a - snap0, 1);

    // Continuous scans of ch0/ch1, start-while-busy ignored, then stop
    cont_a = 1'b1;
    start_a_pulse(8'h03, 1'b0);
    snap1 = busy_low_a;
    expect_a("t4 s0", 0, 32'h100, 0);
    expect_a("t4 s1", 1, 32'h101, 1);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    expect_a("t4 s2", 0, 32'h100, 0);
    expect_a("t4 s3", 1, 32'h101, 1);
    expect_a("t4 s4", 0, 32'h100, 0);
    cont_a = 1'b0;
    expect_a("t4 s5", 1, 32'h101, 1);
    check_eq("t4 busy held", busy_low_a - snap1, 0);
    wait_idle_a("t4");
    snap0 = n_smp_a;
    repeat (100) @(negedge clk);
    check_eq("t4 stopped", n_smp_a - snap0, 0);

    // Instance B: 12-bit, CLK_DIV=1
    @(negedge clk);
    mask_b  = 8'h01;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!smp_valid_b && cyc < 100);
    check_eq("t5 valid",   32'(smp_valid_b),      32'd1);
    check_eq("t5 latency", cyc + 1,               41);
    check_eq("t5 ch",      32'(smp_ch_b),         32'd0);
    check_eq("t5 data",    32'(smp_data_b),       32'hABC);
    check_eq("t5 done",    32'(scan_done_b),      32'd1);
    check_eq("t5 rises",   rise_b,                19);
    check_eq("t5 res0",    32'(results_b[11:0]),  32'hABC);

    // Reset during SHIFT period 10
    use_fixed_a = 1'b1;
    snap0 = n_smp_a;
    start_a_pulse(8'h01, 1'b0);
    cyc = 0;
    while (rise_a != 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6 reached bit10", rise_a, 10);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6 cs_n",      32'(cs_n_a),      32'd1);
    check_eq("t6 sck",       32'(sck_a),       32'd0);
    check_eq("t6 mosi",      32'(mosi_a),      32'd0);
    check_eq("t6 busy",      32'(busy_a),      32'd0);
    check_eq("t6 smp_valid", 32'(smp_valid_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t6 no sample", n_smp_a - snap0, 0);
    check_eq("t6 results",   32'(|results_a),  32'd0);
    start_a_pulse(8'h01, 1'b0);
    wait_smp_a(200, cyc);
    check_eq("t6 latency", cyc + 1, 73);
    check_eq("t6 data",    32'(smp_data_a),     32'h2A5);
    check_eq("t6 rises",   rise_a,              17);
    check_eq("t6 cmd",     32'(cmd_a),          32'b11000);
    check_eq("t6 res0",    32'(results_a[9:0]), 32'h2A5);
    wait_idle_a("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
